// File: rtl/alu_seq_core_pkg.sv
// Shared definitions for the sequential signed ALU: opcodes, FSM states,
// iterative-engine modes and small opcode classifiers.
package alu_seq_core_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ADD = 3'b000;
  localparam opcode_t OP_SUB = 3'b001;
  localparam opcode_t OP_MUL = 3'b010;
  localparam opcode_t OP_DIV = 3'b011;
  localparam opcode_t OP_AND = 3'b100;
  localparam opcode_t OP_OR  = 3'b101;
  localparam opcode_t OP_XOR = 3'b110;
  localparam opcode_t OP_MOD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_e;

  // Ops that need the WIDTH-step engine.
  function automatic logic is_iter(input opcode_t op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Ops that divide (and therefore can hit a zero divisor).
  function automatic logic is_div(input opcode_t op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_core_muldiv.sv
// WIDTH-step iterative engine on unsigned magnitudes.
//   MD_MUL: radix-2 shift-add, prod_or_quot = a_mag * b_mag (2*WIDTH bits).
//   MD_DIV: restoring divide, prod_or_quot = a_mag / b_mag (zero-extended),
//           rem = a_mag % b_mag.
// Ports: clk, reset (sync, active-high), start (load operands), mode,
//        a_mag, b_mag in; prod_or_quot, rem, step_done (high during the last
//        step cycle) out.
module alu_seq_muldiv
  import alu_seq_core_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  md_mode_e           mode,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] prod_or_quot,
  output logic [WIDTH-1:0]   rem,
  output logic               step_done
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  md_mode_e          mode_q;
  logic              active;
  logic [CW-1:0]     cnt;
  logic [DW-1:0]     acc;     // running product, or zero-extended quotient
  logic [DW-1:0]     mcand;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]  q;       // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [WIDTH-1:0]  r;       // partial remainder, always < divisor
  logic [WIDTH-1:0]  d;       // divisor
  logic [WIDTH:0]    r_sh;
  logic [WIDTH-1:0]  q_div;

  // One restoring-division step: bring in next dividend bit, subtract if it fits.
  always_comb begin
    r_sh  = {r, q[WIDTH-1]};
    q_div = {q[WIDTH-2:0], 1'b0};
    if (r_sh >= {1'b0, d}) begin
      q_div[0] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= MD_MUL;
      active    <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      q         <= '0;
      r         <= '0;
      d         <= '0;
      step_done <= 1'b0;
    end else if (start) begin
      mode_q    <= mode;
      active    <= 1'b1;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= {WIDTH'(0), a_mag};
      q         <= (mode == MD_MUL) ? b_mag : a_mag;
      r         <= '0;
      d         <= b_mag;
      step_done <= 1'b0;
    end else if (active) begin
      cnt       <= cnt + 1'b1;
      step_done <= (cnt == CW'(WIDTH - 2));
      if (cnt == CW'(WIDTH - 1)) begin
        active <= 1'b0;
      end
      if (mode_q == MD_MUL) begin
        if (q[0]) begin
          acc <= acc + mcand;
        end
        mcand <= mcand << 1;
        q     <= q >> 1;
      end else begin
        q   <= q_div;
        acc <= {WIDTH'(0), q_div};
        r   <= q_div[0] ? WIDTH'(r_sh - {1'b0, d}) : r_sh[WIDTH-1:0];
      end
    end
  end

  assign prod_or_quot = acc;
  assign rem          = r;

endmodule

// File: rtl/alu_seq_core.sv
// Parametrised signed sequential ALU with busy/done handshake and registered
// status flags. Single-cycle ADD/SUB/AND/OR/XOR; WIDTH-step MUL/DIV/MOD.
// Ports: clk, reset (sync, active-high), start, op, in_a, in_b in;
//        result (2*WIDTH signed), done (1-cycle pulse), busy, zero, neg,
//        ovf, dbz out. All outputs are registers.
module alu_seq_core
  import alu_seq_core_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy,
  output logic               zero,
  output logic               neg,
  output logic               ovf,
  output logic               dbz
);

  localparam int unsigned DW = 2 * WIDTH;

  state_e           state, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  opcode_t          op_q;

  logic             eng_start;
  md_mode_e         eng_mode;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [DW-1:0]    eng_prod;
  logic [WIDTH-1:0] eng_rem;
  logic             eng_step_done;

  logic             div_zero;
  logic             sgn_q;
  logic [WIDTH:0]   sum_c, dif_c;
  logic [WIDTH-1:0] lgc_c;
  logic [DW-1:0]    res_c;
  logic             ovf_c;
  logic             chk_fit;

  // Engine is loaded straight from the ports on the accept edge.
  assign a_mag     = in_a[WIDTH-1] ? (~in_a + 1'b1) : in_a;
  assign b_mag     = in_b[WIDTH-1] ? (~in_b + 1'b1) : in_b;
  assign eng_mode  = is_div(op) ? MD_DIV : MD_MUL;
  assign eng_start = (state == S_IDLE) && start && is_iter(op)
                     && !(is_div(op) && (in_b == '0));

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk          (clk),
    .reset        (reset),
    .start        (eng_start),
    .mode         (eng_mode),
    .a_mag        (a_mag),
    .b_mag        (b_mag),
    .prod_or_quot (eng_prod),
    .rem          (eng_rem),
    .step_done    (eng_step_done)
  );

  assign div_zero = is_div(op_q) && (b_q == '0);
  assign sgn_q    = a_q[WIDTH-1] ^ b_q[WIDTH-1];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (!is_iter(op_q) || div_zero || eng_step_done) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result selection, sign fix-up and overflow from the latched operands.
  always_comb begin
    sum_c   = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
    dif_c   = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
    lgc_c   = '0;
    res_c   = '0;
    ovf_c   = 1'b0;
    chk_fit = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        res_c = {{(WIDTH-1){sum_c[WIDTH]}}, sum_c};
        ovf_c = sum_c[WIDTH] ^ sum_c[WIDTH-1];
      end
      OP_SUB: begin
        res_c = {{(WIDTH-1){dif_c[WIDTH]}}, dif_c};
        ovf_c = dif_c[WIDTH] ^ dif_c[WIDTH-1];
      end
      OP_AND, OP_OR, OP_XOR: begin
        lgc_c = (op_q == OP_AND) ? (a_q & b_q) :
                (op_q == OP_OR)  ? (a_q | b_q) : (a_q ^ b_q);
        res_c = {{WIDTH{lgc_c[WIDTH-1]}}, lgc_c};
      end
      OP_MUL, OP_DIV: begin
        res_c   = sgn_q ? (~eng_prod + 1'b1) : eng_prod;
        chk_fit = 1'b1;
      end
      OP_MOD: begin
        res_c = a_q[WIDTH-1] ? (~{WIDTH'(0), eng_rem} + 1'b1) : {WIDTH'(0), eng_rem};
      end
      default: res_c = '0;
    endcase
    // Representable in WIDTH signed bits iff the top WIDTH+1 bits are all equal.
    if (chk_fit) begin
      ovf_c = ~((&res_c[DW-1:WIDTH-1]) | ~(|res_c[DW-1:WIDTH-1]));
    end
    if (div_zero) begin
      res_c = '0;
      ovf_c = 1'b0;
    end
  end

  // Operand latch, handshake and result/flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_ADD;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_q  <= in_a;
            b_q  <= in_b;
            op_q <= op;
            busy <= 1'b1;
          end
        end
        S_RUN: begin
          if (state_d == S_FIN) busy <= 1'b0;
        end
        S_FIN: begin
          result <= res_c;
          zero   <= (res_c == '0);
          neg    <= res_c[DW-1];
          ovf    <= ovf_c;
          dbz    <= div_zero;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core at WIDTH=8 and WIDTH=16.
module tb_alu_seq_core;
  import alu_seq_core_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset8, start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic [15:0] result8;
  logic        done8, busy8, zero8, neg8, ovf8, dbz8;

  logic        reset16, start16;
  logic [2:0]  op16;
  logic [15:0] a16, b16;
  logic [31:0] result16;
  logic        done16, busy16, zero16, neg16, ovf16, dbz16;

  int errors = 0;
  int checks = 0;
  int lat, bcyc, seen;

  alu_seq_core #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .op(op8), .in_a(a8), .in_b(b8),
    .result(result8), .done(done8), .busy(busy8), .zero(zero8), .neg(neg8),
    .ovf(ovf8), .dbz(dbz8)
  );

  alu_seq_core #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset16), .start(start16), .op(op16), .in_a(a16), .in_b(b16),
    .result(result16), .done(done16), .busy(busy16), .zero(zero16), .neg(neg16),
    .ovf(ovf16), .dbz(dbz16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op on the 8-bit DUT (called #1 after an edge) and wait for done.
  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int l, output int bc);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b;
    l  = 0;
    bc = int'(busy8);
    while (!done8 && l < 60) begin
      @(posedge clk); #1;
      l++;
      if (!done8 && busy8) bc++;
    end
  endtask

  task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int l);
    start16 = 1'b1; op16 = op; a16 = a; b16 = b;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = ~a; b16 = ~b;
    l = 0;
    while (!done16 && l < 60) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic flags8(input string tag, input logic [15:0] res,
                        input logic z, input logic n, input logic o, input logic d);
    chk({tag, ".result"}, 64'(result8), 64'(res));
    chk({tag, ".flags{z,n,o,d}"}, 64'({zero8, neg8, ovf8, dbz8}), 64'({z, n, o, d}));
  endtask

  initial begin
    reset8 = 1'b1; start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    reset16 = 1'b1; start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset8.outputs", 64'({result8, done8, busy8, zero8, neg8, ovf8, dbz8}), 64'(0));
    chk("reset16.outputs", 64'({result16, done16, busy16, zero16, neg16, ovf16, dbz16}), 64'(0));
    reset8 = 1'b0; reset16 = 1'b0;

    // ADD 100+50: overflows 8 signed bits, exact in 16.
    run8(OP_ADD, 8'd100, 8'd50, lat, bcyc);
    chk("add.latency", 64'(lat), 64'(2));
    chk("add.busy_cycles", 64'(bcyc), 64'(1));
    flags8("add", 16'h0096, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("add.done_pulse", 64'(done8), 64'(0));

    // SUB -128-1 and OR sign extension.
    run8(OP_SUB, 8'h80, 8'h01, lat, bcyc);
    flags8("sub_min", 16'hFF7F, 1'b0, 1'b1, 1'b1, 1'b0);
    run8(OP_OR, 8'h80, 8'h01, lat, bcyc);
    flags8("or", 16'hFF81, 1'b0, 1'b1, 1'b0, 1'b0);

    // MUL
    run8(OP_MUL, 8'hF9, 8'd13, lat, bcyc);
    chk("mul.latency", 64'(lat), 64'(9));
    chk("mul.busy_cycles", 64'(bcyc), 64'(8));
    flags8("mul_m7x13", 16'hFFA5, 1'b0, 1'b1, 1'b0, 1'b0);
    run8(OP_MUL, 8'h80, 8'h80, lat, bcyc);
    flags8("mul_min2", 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0);

    // DIV / MOD
    run8(OP_DIV, 8'h9C, 8'd7, lat, bcyc);
    chk("div.latency", 64'(lat), 64'(9));
    flags8("div_m100_7", 16'hFFF2, 1'b0, 1'b1, 1'b0, 1'b0);
    run8(OP_MOD, 8'h9C, 8'd7, lat, bcyc);
    flags8("mod_m100_7", 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0);
    run8(OP_DIV, 8'h80, 8'hFF, lat, bcyc);
    flags8("div_min_m1", 16'h0080, 1'b0, 1'b0, 1'b1, 1'b0);

    // Divide by zero, then back-to-back ADD clears dbz.
    run8(OP_DIV, 8'd5, 8'd0, lat, bcyc);
    chk("dbz.latency", 64'(lat), 64'(2));
    flags8("dbz", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    run8(OP_ADD, 8'd1, 8'd1, lat, bcyc);
    chk("add_after_dbz.latency", 64'(lat), 64'(2));
    flags8("add_after_dbz", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start re-pulsed while busy is ignored.
    start8 = 1'b1; op8 = OP_MUL; a8 = 8'hF9; b8 = 8'd13;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    start8 = 1'b1; op8 = OP_XOR; a8 = 8'h55; b8 = 8'h0F;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 3;
    while (!done8 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ignore.latency", 64'(lat), 64'(9));
    flags8("ignore", 16'hFFA5, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("ignore.no_queue", 64'({done8, busy8}), 64'(0));

    // Reset mid-MUL aborts without done.
    start8 = 1'b1; op8 = OP_MUL; a8 = 8'h12; b8 = 8'h34;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset8 = 1'b1;
    @(posedge clk); #1;
    chk("midreset.outputs", 64'({result8, done8, busy8, zero8, neg8, ovf8, dbz8}), 64'(0));
    reset8 = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen = 1;
    end
    chk("midreset.no_done", 64'(seen), 64'(0));
    run8(OP_XOR, 8'h55, 8'h55, lat, bcyc);
    chk("xor.latency", 64'(lat), 64'(2));
    flags8("xor_self", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

    // WIDTH=16
    run16(OP_MUL, 16'd300, 16'hFF38, lat);
    chk("w16.mul.latency", 64'(lat), 64'(17));
    chk("w16.mul.result", 64'(result16), 64'(32'hFFFF15A0));
    chk("w16.mul.flags{z,n,o,d}", 64'({zero16, neg16, ovf16, dbz16}), 64'(4'b0110));
    run16(OP_ADD, 16'd1000, 16'hFFFF, lat);
    chk("w16.b2b.latency", 64'(lat), 64'(2));
    chk("w16.b2b.result", 64'(result16), 64'(32'h000003E7));
    run16(OP_SUB, 16'h8000, 16'h0001, lat);
    chk("w16.sub.result", 64'(result16), 64'(32'hFFFF7FFF));
    chk("w16.sub.ovf", 64'(ovf16), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
